// File: rtl/pow_calc.sv
// pow_calc: unsigned base^exponent by right-to-left square-and-multiply.
// Latency: 1 cycle per exponent bit up to its highest set bit (exponent 0 finishes at once).
// Backpressure: single operand pair in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake carrying base (WIDTH) and exponent (EXP_W)
//   out_valid/out_ready - result handshake carrying result (WIDTH) and overflow
//   result              - base^exponent, or all-ones when the true result does not fit
//   overflow            - true result exceeds 2^WIDTH-1
module pow_calc #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exponent,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sq_q, sq_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             sq_ovf_q, sq_ovf_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;

    // Full-width products; any nonzero upper half means that product overflowed.
    logic [2*WIDTH-1:0] acc_prod;
    logic [2*WIDTH-1:0] sq_prod;

    assign acc_prod = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, sq_q};
    assign sq_prod  = {{WIDTH{1'b0}}, sq_q} * {{WIDTH{1'b0}}, sq_q};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sq_d       = sq_q;
        e_d        = e_q;
        sq_ovf_d   = sq_ovf_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d    = WIDTH'(1);
                    sq_d     = base;
                    e_d      = exponent;
                    sq_ovf_d = 1'b0;
                    ovf_d    = 1'b0;
                    if (exponent == '0) begin
                        // x^0 = 1 for every x, including 0^0.
                        state_d    = DONE;
                        result_d   = WIDTH'(1);
                        overflow_d = 1'b0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                e_d  = e_q >> 1;
                sq_d = sq_prod[WIDTH-1:0];
                // A squared value that overflowed only matters if a later set
                // exponent bit multiplies it into the accumulator.
                if (sq_prod[2*WIDTH-1:WIDTH] != '0) begin
                    sq_ovf_d = 1'b1;
                end
                if (e_q[0]) begin
                    acc_d = acc_prod[WIDTH-1:0];
                    if ((acc_prod[2*WIDTH-1:WIDTH] != '0) || sq_ovf_q) begin
                        ovf_d = 1'b1;
                    end
                end
                if ((e_q >> 1) == '0) begin
                    state_d    = DONE;
                    result_d   = ovf_d ? '1 : acc_d;
                    overflow_d = ovf_d;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            sq_q       <= '0;
            e_q        <= '0;
            sq_ovf_q   <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sq_q       <= sq_d;
            e_q        <= e_d;
            sq_ovf_q   <= sq_ovf_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pow_calc.sv
// tb_pow_calc: randomized and directed checks of pow_calc against a plain-arithmetic power model.
// Latency: checked per operation as edges from accept to out_valid.
// Backpressure: random out_ready stalls with stability checks on the held result.
module tb_pow_calc;

    localparam int WIDTH = 32;
    localparam int EXP_W = 8;
    localparam int TIMEOUT = 600;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] base;
    logic [EXP_W-1:0] exponent;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    pow_calc #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .base     (base),
        .exponent (exponent),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: repeated multiplication of the true value, stopping once it
    // no longer fits in WIDTH bits. Latency is the bit length of the exponent.
    task automatic model(input logic [WIDTH-1:0] b, input int e,
                         output logic [WIDTH-1:0] r, output logic o, output int lat);
        logic [63:0] v;
        v = 64'd1;
        o = 1'b0;
        for (int i = 0; i < e; i++) begin
            v = v * {32'd0, b};
            if (v > 64'hFFFF_FFFF) begin
                o = 1'b1;
                break;
            end
            if (v == 64'd0) break;
        end
        r = o ? 32'hFFFF_FFFF : v[31:0];
        lat = 0;
        while ((e >> lat) != 0) lat++;
    endtask

    // One full transaction: accept, wait for result, stall, handshake.
    task automatic run_op(input logic [WIDTH-1:0] b, input logic [EXP_W-1:0] e, input int stall);
        logic [WIDTH-1:0] exp_r;
        logic             exp_o;
        int               exp_lat;
        int               cnt;
        model(b, int'(e), exp_r, exp_o, exp_lat);
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        base     = b;
        exponent = e;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Garbage on the operand bus must not disturb the calculation.
        base     = $urandom;
        exponent = EXP_W'($urandom);
        cnt = 0;
        while (!out_valid && cnt < TIMEOUT) begin
            chk("in_ready_calc", 64'(in_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
            base     = $urandom;
            exponent = EXP_W'($urandom);
            cnt++;
        end
        chk("out_valid_timeout", 64'(out_valid), 64'd1);
        chk("latency", 64'(cnt), 64'(exp_lat));
        chk("result", 64'(result), 64'(exp_r));
        chk("overflow", 64'(overflow), 64'(exp_o));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_result", 64'(result), 64'(exp_r));
            chk("stall_overflow", 64'(overflow), 64'(exp_o));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", 64'(out_valid), 64'd0);
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] rb;
        logic [EXP_W-1:0] re;
        int               seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        base      = '0;
        exponent  = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // First accept right after reset release, then directed corner cases.
        run_op(32'd3, 8'd5, 0);
        run_op(32'd2, 8'd31, 0);
        run_op(32'd2, 8'd32, 1);
        run_op(32'd65536, 8'd2, 0);
        run_op(32'd0, 8'd0, 0);
        run_op(32'd0, 8'd7, 0);
        run_op(32'd1, 8'd255, 0);
        run_op(32'd10, 8'd3, 5);
        run_op(32'hFFFF_FFFF, 8'd1, 0);
        run_op(32'hFFFF_FFFF, 8'd2, 2);

        // Reset mid-calculation discards the operation.
        in_valid = 1'b1;
        base     = 32'd7;
        exponent = 8'd200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        pulse_reset();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_out_valid_after_calc_reset", 64'(seen), 64'd0);
        run_op(32'd5, 8'd2, 0);

        // Reset while a result is waiting in DONE.
        in_valid = 1'b1;
        base     = 32'd9;
        exponent = 8'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_before_reset", 64'(out_valid), 64'd1);
        pulse_reset();
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_out_valid_after_done_reset", 64'(seen), 64'd0);

        // Randomized operations across operand magnitudes.
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(0, 3);
                1: rb = $urandom_range(0, 20);
                2: rb = $urandom_range(0, 300);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) re = EXP_W'($urandom_range(0, 40));
            else re = EXP_W'($urandom_range(0, 255));
            run_op(rb, re, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
